// File: rtl/data_mem_responder_if.sv
// Load/store port between core LSU (master) and data memory (slave).
// Request channel carries MemOp sizing; response returns data or error.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_op,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid,
        input  rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_op,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid,
        output rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with RISC-V MemOp sizing.
// Define DATA_MEM_RAND_DELAY_EN for LFSR-driven random extra latency.
module data_mem_responder #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          DEPTH = 4096,
    parameter int          LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    data_mem_responder_if.slave        mem
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [7:0]  cnt;
    logic        wen_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        rdy;
    logic        vld;
    logic        accept;
    logic        commit;
    logic        hold;
    logic [2:0]  extra;

    logic [31:0] ram [DEPTH];

    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        range_err;
    logic        misal;
    logic        illegal;
    logic        err;
    logic        wr_en;
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld_data;
    logic [3:0]  be;
    logic [31:0] wd;

    assign accept = (state == IDLE) && mem.req_valid;
    assign commit = (state == BUSY) && (cnt == 8'd0);

    always_comb begin
        state_n = state;
        rdy     = 1'b0;
        vld     = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (mem.req_valid) state_n = BUSY;
            end
            BUSY: begin
                if (cnt == 8'd0) state_n = RESP;
            end
            RESP: begin
                vld = !hold;
                if (vld && mem.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign off       = addr_q - BASE;
    assign idx       = off[AW+1:2];
    assign range_err = (addr_q < BASE) || ((off >> 2) >= 32'(DEPTH));
    assign misal     = (op_q[1:0] == 2'b01 && addr_q[0])
                     || (op_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    // Stores have no unsigned forms; loads reject 011/110/111.
    assign illegal   = wen_q ? (op_q[2] || op_q[1:0] == 2'b11)
                             : (op_q[1:0] == 2'b11 || op_q == 3'b110);
    assign err       = range_err || misal || illegal;
    assign wr_en     = commit && wen_q && !err;

    always_comb begin
        word    = ram[idx];
        bsel    = word[{addr_q[1:0], 3'b000} +: 8];
        hsel    = addr_q[1] ? word[31:16] : word[15:0];
        ld_data = word;
        be      = 4'b1111;
        wd      = wdata_q;
        unique case (1'b1)
            op_q[1:0] == 2'b00: begin
                ld_data = {{24{bsel[7] & ~op_q[2]}}, bsel};
                be      = 4'b0001 << addr_q[1:0];
                wd      = {4{wdata_q[7:0]}};
            end
            op_q[1:0] == 2'b01: begin
                ld_data = {{16{hsel[15] & ~op_q[2]}}, hsel};
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wd      = {2{wdata_q[15:0]}};
            end
            default: begin
                ld_data = word;
                be      = 4'b1111;
                wd      = wdata_q;
            end
        endcase
    end

    // Storage has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            wen_q   <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                wen_q   <= mem.req_wen;
                op_q    <= mem.req_op;
                addr_q  <= mem.req_addr;
                wdata_q <= mem.req_wdata;
                cnt     <= 8'(LAT - 1) + {5'd0, extra};
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit) begin
                rdata_q <= (err || wen_q) ? 32'd0 : ld_data;
                err_q   <= err;
            end
        end
    end

`ifdef DATA_MEM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_n;

    assign lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign extra  = lfsr_n[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
            hold <= 1'b0;
        end else begin
            if (accept) lfsr <= lfsr_n;
            if (commit) hold <= lfsr[3];
            else if (state == RESP) hold <= 1'b0;
        end
    end
`else
    assign extra = 3'd0;
    assign hold  = 1'b0;
`endif

    assign mem.req_ready = rdy;
    assign mem.rsp_valid = vld;
    assign mem.rsp_rdata = rdata_q;
    assign mem.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: sizing, errors,
// response back-pressure and reset during a pending store.
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .BASE  (32'h8000_0000),
        .DEPTH (4096),
        .LAT   (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mem (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic xact(input string tag,
                        input logic wen,
                        input logic [2:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input int hold,
                        output logic [31:0] rd,
                        output logic er);
        int n;
        int lat;
        rd = 32'd0;
        er = 1'b0;
        @(negedge clk);
        bus.req_wen   = wen;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check({tag, "_acc_timeout"}, 32'(n), 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) begin
            check({tag, "_rsp_timeout"}, 32'(lat), 32'(LAT));
            return;
        end
`ifndef DATA_MEM_RAND_DELAY_EN
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
`endif
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_vld"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_data"}, bus.rsp_rdata, rd);
            check({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic ld(input string tag,
                      input logic [2:0] op,
                      input logic [31:0] addr,
                      input logic [31:0] exp_rd,
                      input logic exp_er);
        logic [31:0] rd;
        logic        er;
        xact(tag, 1'b0, op, addr, 32'd0, 0, rd, er);
        check({tag, "_data"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    task automatic st(input string tag,
                      input logic [2:0] op,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic exp_er);
        logic [31:0] rd;
        logic        er;
        xact(tag, 1'b1, op, addr, wdata, 0, rd, er);
        check({tag, "_data"}, rd, 32'd0);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;

        st("sw10", 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        ld("lw10", 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        st("sb11", 3'b000, 32'h8000_0011, 32'h0000_7F80, 1'b0);
        ld("lw10b", 3'b010, 32'h8000_0010, 32'hDEAD_80EF, 1'b0);
        ld("lb11", 3'b000, 32'h8000_0011, 32'hFFFF_FF80, 1'b0);
        ld("lbu11", 3'b100, 32'h8000_0011, 32'h0000_0080, 1'b0);
        ld("lh12", 3'b001, 32'h8000_0012, 32'hFFFF_DEAD, 1'b0);
        ld("lhu12", 3'b101, 32'h8000_0012, 32'h0000_DEAD, 1'b0);

        st("sw14", 3'b010, 32'h8000_0014, 32'h89AB_CDEF, 1'b0);
        st("sh16", 3'b001, 32'h8000_0016, 32'hFFFF_5566, 1'b0);
        ld("lw14", 3'b010, 32'h8000_0014, 32'h5566_CDEF, 1'b0);
        ld("lb14", 3'b000, 32'h8000_0014, 32'hFFFF_FFEF, 1'b0);
        ld("lh14", 3'b001, 32'h8000_0014, 32'hFFFF_CDEF, 1'b0);
        ld("lbu17", 3'b100, 32'h8000_0017, 32'h0000_0055, 1'b0);

        ld("lw_mis", 3'b010, 32'h8000_0002, 32'd0, 1'b1);
        ld("lh_mis", 3'b001, 32'h8000_0001, 32'd0, 1'b1);
        ld("lw_low", 3'b010, 32'h7FFF_FFFC, 32'd0, 1'b1);
        ld("lw_high", 3'b010, 32'h8000_4000, 32'd0, 1'b1);
        st("sw_top", 3'b010, 32'h8000_3FFC, 32'h0BAD_F00D, 1'b0);
        ld("lw_top", 3'b010, 32'h8000_3FFC, 32'h0BAD_F00D, 1'b0);
        ld("ld_ill", 3'b011, 32'h8000_0010, 32'd0, 1'b1);
        st("st_ill", 3'b100, 32'h8000_0010, 32'h0000_0011, 1'b1);
        st("sw_mis", 3'b010, 32'h8000_0012, 32'h1234_5678, 1'b1);
        ld("lw_keep", 3'b010, 32'h8000_0010, 32'hDEAD_80EF, 1'b0);

        xact("bp", 1'b0, 3'b010, 32'h8000_0010, 32'd0, 5, rd, er);
        check("bp_data", rd, 32'hDEAD_80EF);
        check("bp_err", 32'(er), 32'd0);

        st("sw20", 3'b010, 32'h8000_0020, 32'h1122_3344, 1'b0);
        @(negedge clk);
        bus.req_wen   = 1'b1;
        bus.req_op    = 3'b010;
        bus.req_addr  = 32'h8000_0020;
        bus.req_wdata = 32'hCAFE_BABE;
        bus.req_valid = 1'b1;
        check("pre_rst_rdy", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("busy_rdy", 32'(bus.req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_rdy", 32'(bus.req_ready), 32'd1);
        check("arst_vld", 32'(bus.rsp_valid), 32'd0);
        check("arst_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ld("lw20", 3'b010, 32'h8000_0020, 32'h1122_3344, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
